// File: rtl/bin_sched.sv
// bin_sched: per-bin clause scheduler for a SAT engine.
//
// Flow for one bin:
//   1. Fetch NUM_CLAUSES clauses from memory at {bin, idx}.
//   2. Write each clause into the engine clause array.
//   3. Load the variable and level state, then start the engine.
//   4. Wait for the engine to finish and record the result.
//   5. Read every clause back and send it out on a valid/ready writeback port.
//   6. Report the result on a one-cycle done pulse.
//
// Optional feature (macro BIN_SCHED_WATCHDOG_EN):
//   A RUN-cycle watchdog. If the engine never reports done, it aborts to DONE
//   with timeout_o=1 and skips readback. Without the macro, RUN waits for the
//   engine indefinitely and timeout_o is tied to 0.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   start_i, bin_num_i       solve request; bin sampled together with start_i
//   busy_o                   high in every state except idle
//   done_o                   one-cycle completion pulse
//   sat_o, unsat_o           result flags, valid with done_o
//   timeout_o                watchdog abort flag, valid with done_o
//   mem_req_o, mem_addr_o    clause fetch request and {bin, idx} address
//   mem_ack_i, mem_clause_i  fetch acknowledge; data arrives in the same cycle
//   wr_carray_o, rd_carray_o one-hot engine clause write/read strobes
//   clause_o, clause_i       clause data to and from the engine
//   wr_var_states_o          variable-state load strobe
//   wr_lvl_states_o          level-state load strobe
//   start_core_o             engine start pulse
//   done_core_i              engine done
//   sat_i, unsat_i           engine result, sampled with done_core_i
//   wb_valid_o, wb_clause_o  clause writeback, valid side
//   wb_ready_i               clause writeback, ready side
module bin_sched #(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_LVL   = 16,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic [WIDTH_LVL-1:0]                     bin_num_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     sat_o,
  output logic                                     unsat_o,
  output logic                                     mem_req_o,
  output logic [WIDTH_LVL+$clog2(NUM_CLAUSES)-1:0] mem_addr_o,
  input  logic                                     mem_ack_i,
  input  logic [NUM_VARS*3-1:0]                    mem_clause_i,
  output logic [NUM_CLAUSES-1:0]                   wr_carray_o,
  output logic [NUM_CLAUSES-1:0]                   rd_carray_o,
  output logic [NUM_VARS*3-1:0]                    clause_o,
  input  logic [NUM_VARS*3-1:0]                    clause_i,
  output logic [NUM_VARS-1:0]                      wr_var_states_o,
  output logic                                     wr_lvl_states_o,
  output logic                                     start_core_o,
  input  logic                                     done_core_i,
  input  logic                                     sat_i,
  input  logic                                     unsat_i,
  output logic                                     wb_valid_o,
  output logic [NUM_VARS*3-1:0]                    wb_clause_o,
  input  logic                                     wb_ready_i,
  output logic                                     timeout_o
);

  localparam int unsigned IdxW    = $clog2(NUM_CLAUSES);
  localparam int unsigned ClauseW = NUM_VARS * 3;

  // Elaboration-time sanity check on the configuration.
  if (NUM_CLAUSES < 2 || WDOG_CYCLES < 2) begin : g_cfg_check
    $error("bin_sched: NUM_CLAUSES and WDOG_CYCLES must both be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoadC,
    StLoadVs,
    StStart,
    StRun,
    StRdbk,
    StDone
  } state_e;

  // Sub-steps of the per-clause sequences.
  //   LOAD_C uses PhFetch -> PhStrobe.
  //   RDBK uses PhStrobe -> PhCapture -> PhWb.
  typedef enum logic [1:0] {
    PhFetch,
    PhStrobe,
    PhCapture,
    PhWb
  } phase_e;

  state_e               r_state, w_state_d;
  phase_e               r_phase, w_phase_d;
  logic [IdxW-1:0]      r_idx, w_idx_d;
  logic [WIDTH_LVL-1:0] r_bin, w_bin_d;
  logic [ClauseW-1:0]   r_clause, w_clause_d;
  logic [ClauseW-1:0]   r_wb, w_wb_d;
  logic                 r_sat, w_sat_d;
  logic                 r_unsat, w_unsat_d;
  logic                 w_last_idx;
  logic [NUM_CLAUSES-1:0] w_idx_onehot;

`ifdef BIN_SCHED_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] r_wdog, w_wdog_d;
  logic             r_timeout, w_timeout_d;
`endif

  assign w_last_idx   = (r_idx == IdxW'(NUM_CLAUSES - 1));
  assign w_idx_onehot = {{(NUM_CLAUSES-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_phase   <= PhFetch;
      r_idx     <= '0;
      r_bin     <= '0;
      r_clause  <= '0;
      r_wb      <= '0;
      r_sat     <= 1'b0;
      r_unsat   <= 1'b0;
`ifdef BIN_SCHED_WATCHDOG_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_phase   <= w_phase_d;
      r_idx     <= w_idx_d;
      r_bin     <= w_bin_d;
      r_clause  <= w_clause_d;
      r_wb      <= w_wb_d;
      r_sat     <= w_sat_d;
      r_unsat   <= w_unsat_d;
`ifdef BIN_SCHED_WATCHDOG_EN
      r_wdog    <= w_wdog_d;
      r_timeout <= w_timeout_d;
`endif
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_phase_d  = r_phase;
    w_idx_d    = r_idx;
    w_bin_d    = r_bin;
    w_clause_d = r_clause;
    w_wb_d     = r_wb;
    w_sat_d    = r_sat;
    w_unsat_d  = r_unsat;
`ifdef BIN_SCHED_WATCHDOG_EN
    w_wdog_d    = r_wdog;
    w_timeout_d = r_timeout;
`endif

    busy_o          = (r_state != StIdle);
    done_o          = 1'b0;
    sat_o           = 1'b0;
    unsat_o         = 1'b0;
    timeout_o       = 1'b0;
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    wr_carray_o     = '0;
    rd_carray_o     = '0;
    clause_o        = '0;
    wr_var_states_o = '0;
    wr_lvl_states_o = 1'b0;
    start_core_o    = 1'b0;
    wb_valid_o      = 1'b0;
    wb_clause_o     = '0;

    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_bin_d   = bin_num_i;
          w_idx_d   = '0;
          w_phase_d = PhFetch;
          w_sat_d   = 1'b0;
          w_unsat_d = 1'b0;
`ifdef BIN_SCHED_WATCHDOG_EN
          w_timeout_d = 1'b0;
`endif
          w_state_d = StLoadC;
        end
      end

      StLoadC: begin
        if (r_phase == PhFetch) begin
          mem_req_o  = 1'b1;
          mem_addr_o = {r_bin, r_idx};
          if (mem_ack_i) begin
            w_clause_d = mem_clause_i;
            w_phase_d  = PhStrobe;
          end
        end else begin
          // Write the registered clause; mem_ack_i is ignored here (no request).
          clause_o    = r_clause;
          wr_carray_o = w_idx_onehot;
          w_phase_d   = PhFetch;
          if (w_last_idx) begin
            w_idx_d   = '0;
            w_state_d = StLoadVs;
          end else begin
            w_idx_d = r_idx + IdxW'(1);
          end
        end
      end

      StLoadVs: begin
        wr_var_states_o = '1;
        wr_lvl_states_o = 1'b1;
        w_state_d       = StStart;
      end

      StStart: begin
        start_core_o = 1'b1;
`ifdef BIN_SCHED_WATCHDOG_EN
        // The start cycle counts as the first one, so done_o lands exactly
        // WDOG_CYCLES cycles after start_core_o.
        w_wdog_d = WdogW'(1);
`endif
        w_state_d = StRun;
      end

      StRun: begin
        if (done_core_i) begin
          // A contradictory report (both flags set) is treated as unsat.
          w_unsat_d = unsat_i;
          w_sat_d   = sat_i & ~unsat_i;
          w_idx_d   = '0;
          w_phase_d = PhStrobe;
          w_state_d = StRdbk;
        end
`ifdef BIN_SCHED_WATCHDOG_EN
        else if (r_wdog >= WdogW'(WDOG_CYCLES - 1)) begin
          w_timeout_d = 1'b1;
          w_sat_d     = 1'b0;
          w_unsat_d   = 1'b0;
          w_state_d   = StDone;
        end else begin
          w_wdog_d = r_wdog + WdogW'(1);
        end
`endif
      end

      StRdbk: begin
        case (r_phase)
          PhStrobe: begin
            rd_carray_o = w_idx_onehot;
            w_phase_d   = PhCapture;
          end
          PhCapture: begin
            // The engine returns the clause one cycle after the read strobe.
            w_wb_d    = clause_i;
            w_phase_d = PhWb;
          end
          default: begin
            wb_valid_o  = 1'b1;
            wb_clause_o = r_wb;
            if (wb_ready_i) begin
              w_phase_d = PhStrobe;
              if (w_last_idx) begin
                w_idx_d   = '0;
                w_state_d = StDone;
              end else begin
                w_idx_d = r_idx + IdxW'(1);
              end
            end
          end
        endcase
      end

      StDone: begin
        done_o  = 1'b1;
        sat_o   = r_sat;
        unsat_o = r_unsat;
`ifdef BIN_SCHED_WATCHDOG_EN
        timeout_o = r_timeout;
`endif
        w_state_d = StIdle;
      end

      default: w_state_d = StIdle;
    endcase
  end

endmodule
